// File: rtl/div_pkg.sv
// Shared constants for the programmable clock divider (clk_divider_n).
package div_pkg;

    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned DIV_DEF_DEF   = 6;
    localparam int unsigned DIV_MIN       = 1;

    // Bit positions for a packed status readback word {div_pend, div_err}
    localparam int unsigned STAT_ERR_BIT  = 0;
    localparam int unsigned STAT_PEND_BIT = 1;
    localparam int unsigned STAT_W        = 2;

endpackage

// File: rtl/div_ratio_shadow.sv
// Shadow register for the divide ratio: holds the pending N, the pending flag,
// the load-error pulse and the mux that selects the N for the next period.
module div_ratio_shadow
    import div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DIV_DEF = DIV_DEF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_apply,
    output logic [CNT_W-1:0] o_cur,
    output logic [CNT_W-1:0] o_cur_nxt_c,
    output logic             o_pend,
    output logic             o_err
);

    logic [CNT_W-1:0] r_cur;
    logic [CNT_W-1:0] r_pending;
    logic             r_pend;
    logic             r_err;

    logic             w_load_ok;
    logic [CNT_W-1:0] w_cur_nxt;

    assign w_load_ok = i_load && (i_val >= CNT_W'(DIV_MIN));

    // Next ratio in effect: a same-cycle load beats the stored pending value
    always_comb begin
        w_cur_nxt = r_cur;
        if (i_apply) begin
            if (w_load_ok) begin
                w_cur_nxt = i_val;
            end else if (r_pend) begin
                w_cur_nxt = r_pending;
            end
        end
    end

    // Ratio, pending slot and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur     <= CNT_W'(DIV_DEF);
            r_pending <= '0;
            r_pend    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cur     <= w_cur_nxt;
            r_pending <= w_load_ok ? i_val : r_pending;
            r_pend    <= !i_apply && (w_load_ok || r_pend);
            r_err     <= i_load && !w_load_ok;
        end
    end

    assign o_cur       = r_cur;
    assign o_cur_nxt_c = w_cur_nxt;
    assign o_pend      = r_pend;
    assign o_err       = r_err;

endmodule

// File: rtl/clk_divider_n.sv
// Runtime-programmable integer clock divider with one-cycle enable flag.
// Optional macro DIV_SYNC_EN adds a div_sync input that restarts the period.
module clk_divider_n
    import div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DIV_DEF = DIV_DEF_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             div_en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
`ifdef DIV_SYNC_EN
    input  logic             div_sync,
`endif
    output logic [CNT_W-1:0] div_cur,
    output logic             div_pend,
    output logic             div_err,
    output logic             clk_out,
    output logic             clk_flag
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_flag;
    logic             r_out;

    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_cur_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_apply;
    logic             w_wrap;
    logic             w_sync;
    logic             w_flag_nxt;
    logic             w_out_nxt;

`ifdef DIV_SYNC_EN
    assign w_sync = div_sync;
`else
    assign w_sync = 1'b0;
`endif

    div_ratio_shadow #(
        .CNT_W   (CNT_W),
        .DIV_DEF (DIV_DEF)
    ) u_shadow (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .i_load      (div_load),
        .i_val       (div_val),
        .i_apply     (w_apply),
        .o_cur       (w_cur),
        .o_cur_nxt_c (w_cur_nxt),
        .o_pend      (div_pend),
        .o_err       (div_err)
    );

    assign w_wrap = (r_cnt == (w_cur - CNT_W'(1)));

    // Counter advance; every non-advancing cycle is a period boundary
    always_comb begin
        w_cnt_nxt = '0;
        w_apply   = 1'b1;
        if (div_en && r_run && !w_sync && !w_wrap) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_apply   = 1'b0;
        end
    end

    // Outputs precomputed from next count and next ratio, so they align with r_cnt
    always_comb begin
        w_flag_nxt = div_en && (w_cnt_nxt == (w_cur_nxt - CNT_W'(1)));
        w_out_nxt  = div_en && (w_cnt_nxt < (w_cur_nxt >> 1));
    end

    // Counter, run tracker and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_flag <= 1'b0;
            r_out  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_run  <= div_en;
            r_flag <= w_flag_nxt;
            r_out  <= w_out_nxt;
        end
    end

    assign div_cur  = w_cur;
    assign clk_flag = r_flag;
    assign clk_out  = r_out;

endmodule

// File: tb/tb_clk_divider_n.sv
// Directed testbench for clk_divider_n (covers DIV_SYNC_EN when defined).
module tb_clk_divider_n;

    localparam int unsigned CNT_W = 8;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             div_en;
    logic             div_load;
    logic [CNT_W-1:0] div_val;
`ifdef DIV_SYNC_EN
    logic             div_sync;
`endif
    logic [CNT_W-1:0] div_cur;
    logic             div_pend;
    logic             div_err;
    logic             clk_out;
    logic             clk_flag;

    int n_vec = 0;
    int n_err = 0;

    clk_divider_n #(
        .CNT_W   (CNT_W),
        .DIV_DEF (6)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .div_en    (div_en),
        .div_load  (div_load),
        .div_val   (div_val),
`ifdef DIV_SYNC_EN
        .div_sync  (div_sync),
`endif
        .div_cur   (div_cur),
        .div_pend  (div_pend),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .clk_flag  (clk_flag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fo(input string tag, input logic f, input logic o);
        chk({tag, "_flag"}, 32'(clk_flag), 32'(f));
        chk({tag, "_out"},  32'(clk_out),  32'(o));
    endtask

    task automatic chk_cp(input string tag, input int unsigned cur, input logic p);
        chk({tag, "_cur"},  32'(div_cur),  cur);
        chk({tag, "_pend"}, 32'(div_pend), 32'(p));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        div_en    = 1'b0;
        div_load  = 1'b0;
        div_val   = '0;
`ifdef DIV_SYNC_EN
        div_sync  = 1'b0;
`endif
        step();
        step();
        chk_cp("rst", 6, 1'b0);
        chk("rst_err", 32'(div_err), 32'd0);
        chk_fo("rst", 1'b0, 1'b0);

        // Default N=6: flag at cnt 5, 3 high / 3 low
        sys_rst_n = 1'b1;
        div_en    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_fo("n6", (k % 6) == 5, (k % 6) < 3);
        end
        chk_cp("n6", 6, 1'b0);

        // Load 5 at cnt 2; current period still ends at cnt 5
        for (int k = 0; k < 3; k++) begin
            step();
            chk_fo("pre5", 1'b0, 1'b1);
        end
        div_load = 1'b1; div_val = 8'd5;
        step();
        div_load = 1'b0;
        chk_cp("ld5", 6, 1'b1);
        chk_fo("ld5", 1'b0, 1'b0);
        step();
        step();
        chk_fo("end6", 1'b1, 1'b0);
        chk_cp("end6", 6, 1'b1);
        step();
        chk_cp("ap5", 5, 1'b0);
        chk_fo("ap5", 1'b0, 1'b1);
        for (int k = 1; k < 5; k++) begin
            step();
            chk_fo("n5", k == 4, k < 2);
        end

        // Load 9 then 4 in one period: only 4 takes effect
        step();
        div_load = 1'b1; div_val = 8'd9;
        step();
        div_load = 1'b0;
        chk_cp("ld9", 5, 1'b1);
        step();
        div_load = 1'b1; div_val = 8'd4;
        step();
        div_load = 1'b0;
        chk_cp("ld4", 5, 1'b1);
        step();
        chk_fo("end5", 1'b1, 1'b0);
        chk("end5_cur", 32'(div_cur), 32'd5);
        step();
        chk_cp("ap4", 4, 1'b0);
        chk_fo("ap4", 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("n4_cur", 32'(div_cur), 32'd4);
            chk_fo("n4", k == 3, k < 2);
        end

        // Load 0 at the boundary: error pulse, ratio unchanged
        div_load = 1'b1; div_val = 8'd0;
        step();
        div_load = 1'b0;
        chk("z_err", 32'(div_err), 32'd1);
        chk_cp("z", 4, 1'b0);
        chk_fo("z", 1'b0, 1'b1);
        step();
        chk("z_err_clr", 32'(div_err), 32'd0);
        step();
        step();
        chk_fo("z_end", 1'b1, 1'b0);
        chk("z_end_cur", 32'(div_cur), 32'd4);

        // Load 1 at cnt==N-1: applies to the very next period
        div_load = 1'b1; div_val = 8'd1;
        step();
        div_load = 1'b0;
        chk_cp("n1", 1, 1'b0);
        chk_fo("n1", 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_fo("n1_run", 1'b1, 1'b0);
        end

        // Load 2: flag every 2 cycles, 1 high / 1 low
        div_load = 1'b1; div_val = 8'd2;
        step();
        div_load = 1'b0;
        chk_cp("n2", 2, 1'b0);
        chk_fo("n2", 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk_fo("n2_run", (k % 2) == 1, (k % 2) == 0);
        end

        // Back to 6, then disable at cnt 3 with 7 pending
        div_load = 1'b1; div_val = 8'd6;
        step();
        div_load = 1'b0;
        chk("b6_cur", 32'(div_cur), 32'd6);
        step();
        step();
        div_load = 1'b1; div_val = 8'd7;
        step();
        div_load = 1'b0;
        chk_cp("ld7", 6, 1'b1);
        div_en = 1'b0;
        step();
        chk_cp("dis", 7, 1'b0);
        chk_fo("dis", 1'b0, 1'b0);
        step();
        chk_fo("dis2", 1'b0, 1'b0);
        div_en = 1'b1;
        step();
        chk_fo("ren", 1'b0, 1'b1);
        for (int k = 1; k < 7; k++) begin
            step();
            chk_fo("n7", k == 6, k < 3);
        end

`ifdef DIV_SYNC_EN
        // Sync at cnt 2 truncates the period without a flag
        div_load = 1'b1; div_val = 8'd6;
        step();
        div_load = 1'b0;
        chk("s6_cur", 32'(div_cur), 32'd6);
        step();
        step();
        div_sync = 1'b1;
        step();
        div_sync = 1'b0;
        chk_fo("sync", 1'b0, 1'b1);
        for (int k = 1; k < 6; k++) begin
            step();
            chk_fo("post_sync", k == 5, k < 3);
        end
`endif

        // Reset mid-period discards the pending value
        step();
        div_load = 1'b1; div_val = 8'd9;
        step();
        div_load = 1'b0;
        chk("mid_pend", 32'(div_pend), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk_cp("arst", 6, 1'b0);
        chk_fo("arst", 1'b0, 1'b0);
        step();
        sys_rst_n = 1'b1;
        step();
        chk_cp("post_rst", 6, 1'b0);
        chk_fo("post_rst", 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
